// File: rtl/cg_countdown_timer.sv
// cg_countdown_timer
//   Programmable down-counting timer. A load with a non-zero period starts a
//   countdown from P; when the count reaches its last cycle the timer emits a
//   one-cycle expiry pulse and either stops (one-shot) or reloads P (periodic).
//   Shared timeout / watchdog / tick source for protocol blocks.
//
// Ports
//   i_clk      clock, all logic on the rising edge
//   i_rst      synchronous active-high reset
//   i_load     start/restart with i_period and i_mode
//   i_period   period in cycles, sampled only on an accepted load
//   i_mode     0 = one-shot, 1 = periodic, sampled with i_period
//   i_pause    level; freezes the count while high
//   i_cancel   abort to IDLE without an expiry
//   o_count    remaining cycles
//   o_busy     high while running
//   o_expire   one-cycle pulse per expiry
//   o_err      one-cycle pulse when a zero-period load is rejected
//   o_exp_cnt  expiries since the last accepted load, saturating
module cg_countdown_timer #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned EXP_WIDTH  = 8
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_load,
    input  logic [DATA_WIDTH-1:0] i_period,
    input  logic                  i_mode,
    input  logic                  i_pause,
    input  logic                  i_cancel,
    output logic [DATA_WIDTH-1:0] o_count,
    output logic                  o_busy,
    output logic                  o_expire,
    output logic                  o_err,
    output logic [EXP_WIDTH-1:0]  o_exp_cnt
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

    state_e                state_q,   state_d;
    logic [DATA_WIDTH-1:0] count_q,   count_d;
    logic [DATA_WIDTH-1:0] period_q,  period_d;
    logic                  mode_q,    mode_d;
    logic                  expire_q,  expire_d;
    logic                  err_q,     err_d;
    logic [EXP_WIDTH-1:0]  exp_cnt_q, exp_cnt_d;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q   <= IDLE;
            count_q   <= '0;
            period_q  <= '0;
            mode_q    <= 1'b0;
            expire_q  <= 1'b0;
            err_q     <= 1'b0;
            exp_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            period_q  <= period_d;
            mode_q    <= mode_d;
            expire_q  <= expire_d;
            err_q     <= err_d;
            exp_cnt_q <= exp_cnt_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        period_d  = period_q;
        mode_d    = mode_q;
        expire_d  = 1'b0;
        err_d     = 1'b0;
        exp_cnt_d = exp_cnt_q;

        if (i_cancel) begin
            state_d = IDLE;
            count_d = '0;
        end else if (i_load && (i_period != '0)) begin
            // Accepted load wins over any expiry due on this edge.
            state_d   = RUN;
            count_d   = i_period;
            period_d  = i_period;
            mode_d    = i_mode;
            exp_cnt_d = '0;
        end else begin
            // A rejected zero-period load only flags an error; the running
            // countdown carries on as if no load had been presented.
            if (i_load) begin
                err_d = 1'b1;
            end
            if ((state_q == RUN) && !i_pause) begin
                if (count_q > DATA_WIDTH'(1)) begin
                    count_d = count_q - DATA_WIDTH'(1);
                end else begin
                    expire_d = 1'b1;
                    if (exp_cnt_q != '1) begin
                        exp_cnt_d = exp_cnt_q + EXP_WIDTH'(1);
                    end
                    if (mode_q) begin
                        count_d = period_q;
                    end else begin
                        count_d = '0;
                        state_d = IDLE;
                    end
                end
            end
        end
    end

    assign o_count   = count_q;
    assign o_busy    = (state_q == RUN);
    assign o_expire  = expire_q;
    assign o_err     = err_q;
    assign o_exp_cnt = exp_cnt_q;

endmodule

// File: doc/cg_countdown_timer.md
# cg_countdown_timer

Programmable down-counting timer, the counterpart to the free-running up-counter used across the design. It loads a period and decrements to zero, emits a one-cycle expiry pulse, and either stops (one-shot) or reloads automatically (periodic). It is the shared timeout, watchdog and tick generator for protocol blocks that need a deadline rather than an elapsed-time value.

## Interface
- DATA_WIDTH, 32, width of period and count
- EXP_WIDTH, 8, width of the saturating expiry counter
- i_clk  input  1  clock; all logic on rising edge
- i_rst  input  1  synchronous, active-high reset
- i_load  input  1  start or restart with i_period and i_mode
- i_period  input  DATA_WIDTH  period in cycles, sampled only when i_load is accepted
- i_mode  input  1  0 = one-shot, 1 = periodic; sampled with i_period
- i_pause  input  1  level; freezes the count while high
- i_cancel  input  1  abort; return to IDLE without expiry
- o_count  output  DATA_WIDTH  remaining cycles
- o_busy  output  1  high in RUN
- o_expire  output  1  one-cycle pulse per expiry
- o_err  output  1  one-cycle pulse when a load with i_period == 0 is rejected
- o_exp_cnt  output  EXP_WIDTH  expiries since last accepted load; saturates at all-ones

## Operation
- Reset values: state IDLE, o_count 0, o_busy 0, o_expire 0, o_err 0, o_exp_cnt 0, latched period 0, latched mode 0.
- States:
  - IDLE: o_busy = 0.
  - RUN: o_busy = 1.
  - o_busy is decoded from the state register.
- Per-edge priority: i_rst > i_cancel > i_load > i_pause > decrement/expiry.
- i_cancel (any state):
  - Next state IDLE, o_count 0.
  - No o_expire pulse. o_exp_cnt is unchanged.
- i_load with i_period != 0 (any state, including a retrigger from RUN):
  - Latch period P and mode. o_count = P, state RUN, o_exp_cnt = 0.
  - Any expiry due on that same edge is discarded.
- i_load with i_period == 0:
  - o_err pulses for one cycle.
  - State, count, latched values and o_exp_cnt are unchanged.
- RUN with i_pause high: o_count holds. The state stays RUN and o_busy stays 1.
- RUN with i_pause low and o_count > 1: o_count decrements by 1.
- RUN with i_pause low and o_count == 1 (expiry edge):
  - o_expire is registered high for the following cycle.
  - o_exp_cnt increments unless it is all-ones.
  - One-shot: o_count becomes 0 and the state goes to IDLE.
  - Periodic: o_count reloads the latched P and the state stays RUN. There is no zero cycle.
- P = 1 in periodic mode: o_expire stays high on every unpaused cycle. o_count stays at 1.
- Changes to i_period or i_mode while in RUN have no effect until the next accepted load.
- Arithmetic is unsigned, width DATA_WIDTH. The count never wraps below 0.

## Timing
- All outputs are registered. There are no combinational paths from inputs to outputs.
- A load accepted at edge k shows o_count = P and o_busy = 1 in the cycle after k.
- With no pause, the expiry edge is k+P. o_expire is high in the cycle after edge k+P.
- Each paused cycle delays the expiry by exactly one cycle.
- Periodic mode: o_expire pulses every P cycles, measured from the previous pulse, with pauses excluded.
- o_err has 1-cycle latency from the rejected load.
- i_cancel or i_rst at any edge takes effect at that edge. An expiry due at that edge produces no pulse.

## Test plan
- Reset, then one-shot load with P = 5 at edge 0:
  - o_count reads 5,4,3,2,1 in the following cycles, then 0 with o_busy = 0.
  - o_expire is high only in the cycle o_count first reads 0. o_exp_cnt = 1.
- Periodic load with P = 3, run 10 cycles:
  - o_count sequence 3,2,1,3,2,1,3,2,1,3.
  - o_expire high in the 3 cycles where o_count reloads to 3. o_exp_cnt = 3.
- One-shot load with P = 4, i_pause high for 2 cycles while o_count = 2:
  - Count holds at 2 for those cycles and o_busy stays 1.
  - Expiry comes exactly 2 cycles later than it does with no pause.
- Cases on the expiry edge (o_count = 1, unpaused):
  - i_load with P = 7: o_count = 7, no o_expire, o_exp_cnt = 0.
  - i_cancel: o_count = 0, IDLE, no o_expire.
  - i_rst: all outputs at their reset values.
- Load with i_period = 0 while in RUN with o_count = 9:
  - o_err pulses once. The count keeps decrementing (8 in the next cycle).
- EXP_WIDTH = 2, periodic P = 1, run 6 cycles:
  - o_expire stays high from the cycle after the load until the end of the run.
  - o_exp_cnt saturates at 3. A new load clears it to 0.
